// File: rtl/fifo_ptr_counter.sv
// Pointer and occupancy controller for a synchronous FIFO array.
// Produces read/write pointers, full/pending flags and sticky error flags.
module fifo_ptr_counter #(
  parameter  int depth = 4,
  localparam int PTR_W = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  output logic             full,
  output logic             pndng,
  output logic [PTR_W-1:0] pointer_in,
  output logic [PTR_W-1:0] pointer_out,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(depth);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_cnt;
  logic             r_ovf;
  logic             r_unf;

  logic w_full;
  logic w_pndng;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_full    = (r_cnt == DEPTH_C);
  assign w_pndng   = (r_cnt != '0);
  // A push into a full FIFO is fine when a pop frees the head slot.
  assign w_push_ok = push & (~w_full | pop);
  assign w_pop_ok  = pop & w_pndng;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      if (w_push_ok)
        r_wptr <= r_wptr + PTR_ONE;
      if (w_pop_ok)
        r_rptr <= r_rptr + PTR_ONE;
      if (w_push_ok && !w_pop_ok)
        r_cnt <= r_cnt + CNT_ONE;
      else if (w_pop_ok && !w_push_ok)
        r_cnt <= r_cnt - CNT_ONE;
      if (push && w_full && !pop)
        r_ovf <= 1'b1;
      if (pop && !w_pndng)
        r_unf <= 1'b1;
    end
  end

  assign full        = w_full;
  assign pndng       = w_pndng;
  assign pointer_in  = r_wptr;
  assign pointer_out = r_rptr;
  assign count       = r_cnt;
  assign overflow    = r_ovf;
  assign underflow   = r_unf;

endmodule

// File: tb/tb_fifo_ptr_counter.sv
// Scoreboard bench for fifo_ptr_counter (depth 4).
// Directed vectors carry hand-computed post-edge state.
module tb_fifo_ptr_counter;

  logic       clk = 1'b0;
  logic       rst, push, pop;
  logic       full, pndng, overflow, underflow;
  logic [1:0] pointer_in, pointer_out;
  logic [2:0] count;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       r;
    logic       pu;
    logic       po;
    logic [1:0] pin;
    logic [1:0] pout;
    logic [2:0] cnt;
    logic       f;
    logic       p;
    logic       o;
    logic       u;
  } vec_t;

  typedef struct packed {
    logic [1:0] pin;
    logic [1:0] pout;
    logic [2:0] cnt;
    logic       f;
    logic       p;
    logic       o;
    logic       u;
  } st_t;

  vec_t vecs[$];
  st_t  sb[$];
  int   tags[$];
  bit   stim_done = 1'b0;

  fifo_ptr_counter #(.depth(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .full       (full),
    .pndng      (pndng),
    .pointer_in (pointer_in),
    .pointer_out(pointer_out),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic pu, input logic po,
                     input int pin, input int pout, input int cnt,
                     input logic f, input logic p,
                     input logic o, input logic u);
    vec_t v;
    v.r = r; v.pu = pu; v.po = po;
    v.pin = 2'(pin); v.pout = 2'(pout); v.cnt = 3'(cnt);
    v.f = f; v.p = p; v.o = o; v.u = u;
    vecs.push_back(v);
  endtask

  initial begin
    // reset and idle
    add(1,0,0, 0,0,0, 0,0,0,0);
    add(0,0,0, 0,0,0, 0,0,0,0);
    // fill
    add(0,1,0, 1,0,1, 0,1,0,0);
    add(0,1,0, 2,0,2, 0,1,0,0);
    add(0,1,0, 3,0,3, 0,1,0,0);
    add(0,1,0, 0,0,4, 1,1,0,0);
    // push while full: overflow, state holds
    add(0,1,0, 0,0,4, 1,1,1,0);
    add(0,0,0, 0,0,4, 1,1,1,0);
    // drain
    add(0,0,1, 0,1,3, 0,1,1,0);
    add(0,0,1, 0,2,2, 0,1,1,0);
    add(0,0,1, 0,3,1, 0,1,1,0);
    add(0,0,1, 0,0,0, 0,0,1,0);
    // pop while empty: underflow
    add(0,0,1, 0,0,0, 0,0,1,1);
    add(1,0,0, 0,0,0, 0,0,0,0);
    // push+pop when empty
    add(0,1,1, 1,0,1, 0,1,0,1);
    add(0,1,0, 2,0,2, 0,1,0,1);
    add(0,1,0, 3,0,3, 0,1,0,1);
    add(0,1,0, 0,0,4, 1,1,0,1);
    // push+pop when full
    add(0,1,1, 1,1,4, 1,1,0,1);
    add(0,1,1, 2,2,4, 1,1,0,1);
    add(1,0,0, 0,0,0, 0,0,0,0);
    // toggling push with reset mid-sequence
    add(0,1,0, 1,0,1, 0,1,0,0);
    add(0,0,0, 1,0,1, 0,1,0,0);
    add(0,1,0, 2,0,2, 0,1,0,0);
    add(0,0,0, 2,0,2, 0,1,0,0);
    add(0,1,0, 3,0,3, 0,1,0,0);
    add(1,1,0, 0,0,0, 0,0,0,0);
    add(0,1,0, 1,0,1, 0,1,0,0);
    add(0,0,0, 1,0,1, 0,1,0,0);
    add(0,1,0, 2,0,2, 0,1,0,0);
    add(0,0,0, 2,0,2, 0,1,0,0);

    rst = 1'b1; push = 1'b0; pop = 1'b0;
    foreach (vecs[i]) begin
      st_t e;
      @(negedge clk);
      rst  = vecs[i].r;
      push = vecs[i].pu;
      pop  = vecs[i].po;
      @(posedge clk);
      e.pin  = vecs[i].pin;
      e.pout = vecs[i].pout;
      e.cnt  = vecs[i].cnt;
      e.f    = vecs[i].f;
      e.p    = vecs[i].p;
      e.o    = vecs[i].o;
      e.u    = vecs[i].u;
      sb.push_back(e);
      tags.push_back(i);
    end
    stim_done = 1'b1;
  end

  // monitor: outputs are registered, so each edge yields one result
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        st_t e, a;
        int  t;
        e = sb.pop_front();
        t = tags.pop_front();
        a = {pointer_in, pointer_out, count, full, pndng,
             overflow, underflow};
        n_run++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL vec%0d pin/pout/cnt/f/p/o/u got %0d/%0d/%0d/%b/%b/%b/%b want %0d/%0d/%0d/%b/%b/%b/%b",
                   t, a.pin, a.pout, a.cnt, a.f, a.p, a.o, a.u,
                   e.pin, e.pout, e.cnt, e.f, e.p, e.o, e.u);
        end
      end
    end
  end

  initial begin
    int guard = 0;
    while (!(stim_done && sb.size() == 0) && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      n_run++;
      n_fail++;
      $display("FAIL timeout got %0d pending want 0", sb.size());
    end
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ptr_counter.md
Name:
fifo_ptr_counter

Overview:
- Pointer/occupancy controller for a synchronous FIFO memory.
- Generates the write pointer (pointer_in) and read pointer (pointer_out) for a depth-entry storage array.
- Generates the full and pending (non-empty) status flags, an occupancy count, and sticky error flags.
- Sits beside the FIFO storage array; the array writes at pointer_in and reads at pointer_out.

Parameters:
- depth, 4, number of FIFO entries; power of two, at least 2.
- PTR_W, $clog2(depth), derived pointer width; not to be overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- push  in  1  write request; one entry per cycle while high.
- pop  in  1  read request; one entry per cycle while high.
- full  out  1  high when count == depth.
- pndng  out  1  high when count != 0 (unread data present).
- pointer_in  out  PTR_W  address of the next write.
- pointer_out  out  PTR_W  address of the next read.
- count  out  PTR_W+1  current occupancy, 0..depth.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset: rst is sampled only on the rising clk edge, is active-high, and has priority over push/pop.
  - Reset values: pointer_in=0, pointer_out=0, count=0, full=0, pndng=0, overflow=0, underflow=0.
  - Reset asserted mid-operation discards all occupancy on that edge.
- Acceptance, evaluated on each rising edge from registered state:
  - push_ok = push & (~full | pop).
  - pop_ok = pop & pndng.
- Pointers:
  - pointer_in increments by 1 modulo depth when push_ok is high.
  - pointer_out increments by 1 modulo depth when pop_ok is high.
  - Wrap: depth-1 -> 0.
  - The storage writes mem[pointer_in] on the same edge that push_ok is sampled; pointer_out addresses the current head entry.
- count:
  - +1 when push_ok & ~pop_ok.
  - -1 when pop_ok & ~push_ok.
  - Unchanged when both or neither are accepted.
  - Never exceeds depth; never goes below 0.
- Simultaneous push and pop:
  - Empty: only the push is accepted; count 0 -> 1, pointer_out holds, underflow is set.
  - Full: both are accepted; count stays at depth and both pointers advance.
  - Otherwise: both are accepted and count is unchanged.
- Flags:
  - full and pndng are decoded combinationally from the registered count, so they are valid in the cycle after the causing edge.
  - When count==depth, pointer_in==pointer_out.
- Error flags:
  - overflow is set when push & full & ~pop.
  - underflow is set when pop & ~pndng.
  - Both hold until reset; a rejected operation changes no other state.
- Latency: every status output reflects an accepted operation one clock after it is sampled; there is no combinational path from push/pop to any output.

Test Plan:
1. Reset, then one idle cycle -> pointer_in=0, pointer_out=0, count=0, full=0, pndng=0, overflow=0, underflow=0.
2. Push for 4 consecutive cycles (depth=4) -> pointer_in steps 1,2,3,0; count steps 1..4; pndng=1 after the first edge; full=1 after the fourth edge.
3. While full, push without pop -> all pointers and count hold; overflow=1 and stays 1 until rst.
4. From full, pop for 4 cycles -> pointer_out steps 1,2,3,0; count steps to 0; full drops after the first pop; pndng drops after the fourth. A fifth pop -> underflow=1, pointer_out holds at 0.
5. Simultaneous push+pop:
   - when empty -> count=1, pointer_in+1, pointer_out unchanged, underflow=1.
   - when full -> count stays 4, both pointers advance, no overflow.
6. Alternate push with a clock-rate toggle for 10 cycles, assert rst mid-sequence -> next edge returns all outputs to reset values; counting resumes from pointer_in=0.
